// File: rtl/cond_logic_unit.sv
// Conditional-execution unit: holds NZCV flags, evaluates Cond, gates write strobes.
// Optional macro FLAGS_OUT_EN exposes the registered flags on output port Flags.
module cond_logic_unit #(
   parameter int unsigned COND_W = 4,
   parameter int unsigned FLAG_W = 4
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [COND_W-1:0] Cond,
   input  logic [FLAG_W-1:0] ALUFlags,
   input  logic [1:0]        FlagW,
   input  logic              PCS,
   input  logic              RegW,
   input  logic              MemW,
   input  logic              NoWrite,
   output logic              PCSrc,
   output logic              RegWrite,
   output logic              MemWrite,
   output logic              CondEx
`ifdef FLAGS_OUT_EN
   ,
   output logic [FLAG_W-1:0] Flags
`endif
);

   logic [1:0] flags_nz_q;
   logic [1:0] flags_cv_q;
   logic       flag_n, flag_z, flag_c, flag_v;
   logic       wr_nz, wr_cv;

   assign flag_n = flags_nz_q[1];
   assign flag_z = flags_nz_q[0];
   assign flag_c = flags_cv_q[1];
   assign flag_v = flags_cv_q[0];

   always_comb begin
      CondEx = 1'b0;
      unique case (Cond)
         4'b0000: CondEx = flag_z;
         4'b0001: CondEx = ~flag_z;
         4'b0010: CondEx = flag_c;
         4'b0011: CondEx = ~flag_c;
         4'b0100: CondEx = flag_n;
         4'b0101: CondEx = ~flag_n;
         4'b0110: CondEx = flag_v;
         4'b0111: CondEx = ~flag_v;
         4'b1000: CondEx = flag_c & ~flag_z;
         4'b1001: CondEx = ~flag_c | flag_z;
         4'b1010: CondEx = (flag_n == flag_v);
         4'b1011: CondEx = (flag_n != flag_v);
         4'b1100: CondEx = ~flag_z & (flag_n == flag_v);
         4'b1101: CondEx = flag_z | (flag_n != flag_v);
         4'b1110: CondEx = 1'b1;
         4'b1111: CondEx = 1'b0;
         default: CondEx = 1'b0;
      endcase
   end

   // Gate write enables with CondEx first so an unknown FlagW on a squashed
   // instruction cannot reach the flag registers.
   assign wr_nz = FlagW[1] & CondEx;
   assign wr_cv = FlagW[0] & CondEx;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         flags_nz_q <= 2'b00;
         flags_cv_q <= 2'b00;
      end else begin
         if (wr_nz) flags_nz_q <= ALUFlags[3:2];
         if (wr_cv) flags_cv_q <= ALUFlags[1:0];
      end
   end

   assign PCSrc    = PCS & CondEx;
   assign RegWrite = RegW & CondEx & ~NoWrite;
   assign MemWrite = MemW & CondEx;

`ifdef FLAGS_OUT_EN
   assign Flags = {flags_nz_q, flags_cv_q};
`endif

endmodule

// File: tb/tb_cond_logic_unit.sv
// Scoreboard bench for cond_logic_unit: driver queues expected strobes, monitor checks them.
module tb_cond_logic_unit;

   logic       CLK = 1'b0;
   logic       Reset;
   logic [3:0] Cond;
   logic [3:0] ALUFlags;
   logic [1:0] FlagW;
   logic       PCS, RegW, MemW, NoWrite;
   logic       PCSrc, RegWrite, MemWrite, CondEx;
`ifdef FLAGS_OUT_EN
   logic [3:0] Flags;
`endif

   cond_logic_unit dut (
      .CLK      (CLK),
      .Reset    (Reset),
      .Cond     (Cond),
      .ALUFlags (ALUFlags),
      .FlagW    (FlagW),
      .PCS      (PCS),
      .RegW     (RegW),
      .MemW     (MemW),
      .NoWrite  (NoWrite),
      .PCSrc    (PCSrc),
      .RegWrite (RegWrite),
      .MemWrite (MemWrite),
      .CondEx   (CondEx)
`ifdef FLAGS_OUT_EN
      ,
      .Flags    (Flags)
`endif
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string      name;
      logic [3:0] exp;   // {CondEx, PCSrc, RegWrite, MemWrite}
   } sb_entry_t;

   sb_entry_t exp_q[$];
   int        total = 0;
   int        bad   = 0;

   // Reference condition table.
   function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v;
      {n, z, cf, v} = f;
      case (c)
         4'd0:  return z;
         4'd1:  return !z;
         4'd2:  return cf;
         4'd3:  return !cf;
         4'd4:  return n;
         4'd5:  return !n;
         4'd6:  return v;
         4'd7:  return !v;
         4'd8:  return cf && !z;
         4'd9:  return !cf || z;
         4'd10: return n == v;
         4'd11: return n != v;
         4'd12: return !z && (n == v);
         4'd13: return z || (n != v);
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive(input string nm, input logic rst, input logic [3:0] c,
                        input logic [1:0] fw, input logic [3:0] alu, input logic pcs,
                        input logic regw, input logic memw, input logic nowr,
                        input logic [3:0] exp);
      sb_entry_t e;
      @(posedge CLK);
      #1;
      Reset = rst; Cond = c; FlagW = fw; ALUFlags = alu;
      PCS = pcs; RegW = regw; MemW = memw; NoWrite = nowr;
      e.name = nm;
      e.exp  = exp;
      exp_q.push_back(e);
   endtask

   // Read the four flags back through MI/EQ/CS/VS with no flag writes.
   task automatic probe(input string nm, input logic [3:0] f);
      drive({nm, "_N"}, 1'b0, 4'b0100, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, {f[3], f[3], 2'b00});
      drive({nm, "_Z"}, 1'b0, 4'b0000, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, {f[2], f[2], 2'b00});
      drive({nm, "_C"}, 1'b0, 4'b0010, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, {f[1], f[1], 2'b00});
      drive({nm, "_V"}, 1'b0, 4'b0110, 2'b00, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, {f[0], f[0], 2'b00});
   endtask

   // Monitor: combinational outputs are checked mid-cycle against the queued entry.
   initial begin
      sb_entry_t  e;
      logic [3:0] act;
      forever begin
         @(negedge CLK);
         if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {CondEx, PCSrc, RegWrite, MemWrite};
            total++;
            if (act !== e.exp) begin
               bad++;
               $display("FAIL %s: got %b expected %b (CondEx,PCSrc,RegWrite,MemWrite)",
                        e.name, act, e.exp);
            end
         end
      end
   end

   initial begin
      logic [3:0] ce;
      Reset = 1'b1; Cond = 4'h0; FlagW = 2'b00; ALUFlags = 4'h0;
      PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; NoWrite = 1'b0;
      @(posedge CLK);

      // 1: after reset Z=0
      drive("rst_eq", 1'b0, 4'b0000, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      drive("rst_al", 1'b0, 4'b1110, 2'b00, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111);
      probe("rst_flags", 4'b0000);

      // 2: set Z
      drive("set_z",  1'b0, 4'b1110, 2'b11, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
      drive("eq_z1",  1'b0, 4'b0000, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
      drive("ne_z1",  1'b0, 4'b0001, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
      probe("flags_0100", 4'b0100);

      // 3: failed condition squashes strobes and flag write
      drive("ne_fail", 1'b0, 4'b0001, 2'b11, 4'b1011, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      probe("hold_0100", 4'b0100);

      // 4: only N,Z written
      drive("set_0011", 1'b0, 4'b1110, 2'b11, 4'b0011, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
      drive("nz_only",  1'b0, 4'b1110, 2'b10, 4'b1010, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
      probe("flags_1011", 4'b1011);

      // 5: CMP suppresses register write but updates flags
      drive("cmp",     1'b0, 4'b1110, 2'b11, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1000);
      probe("flags_0110", 4'b0110);
      drive("regw_ok", 1'b0, 4'b1110, 2'b00, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1010);
      drive("memw_ok", 1'b0, 4'b1110, 2'b00, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1001);

      // only C,V written
      drive("cv_only", 1'b0, 4'b1110, 2'b01, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
      probe("flags_0101", 4'b0101);

      // reserved condition: no strobes, no flag update, unknown FlagW harmless
      drive("nv_fw11", 1'b0, 4'b1111, 2'b11, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      drive("nv_fwx",  1'b0, 4'b1111, 2'bxx, 4'b1010, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      probe("hold_0101", 4'b0101);

      // reset in flight: strobes not forced, flags cleared next edge
      drive("rst_mid", 1'b1, 4'b1110, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0, 4'b1111);
      probe("rst_mid_flags", 4'b0000);

      // 6: full sweep
      for (int f = 0; f < 16; f++) begin
         drive("sweep_set", 1'b0, 4'b1110, 2'b11, 4'(f), 1'b0, 1'b0, 1'b0, 1'b0, 4'b1000);
         for (int c = 0; c < 16; c++) begin
            ce = {4{ref_cond(4'(c), 4'(f))}};
            drive($sformatf("sweep_c%0d_f%0d", c, f), 1'b0, 4'(c), 2'b00, 4'h0,
                  1'b1, 1'b1, 1'b1, 1'b0, ce);
         end
      end

      repeat (3) @(posedge CLK);
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
